timer_count_ctrl: RTL and testbench
===================================

# timer_count_ctrl

Count-control stage of the two-mode timer: generates the next minutes/seconds value that the 8-bit display registers capture, and runs the stopwatch/countdown state machine driving it. Holds BCD minutes (00–99) and seconds (00–59), advances once per prescaled 1 s tick, supports preset load, pause/resume and clear. Outputs feed the 8-bit register stage and the seven-segment decode path directly.

## Interface
- TICK_DIV, 50_000_000, clk cycles per 1 s tick; must be at least 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode_sel  in  1  0 = stopwatch (count up), 1 = countdown; sampled only in IDLE
- start  in  1  level, start/resume
- stop  in  1  level, pause
- clear  in  1  level, zero count, return to IDLE
- load  in  1  level, load preset
- load_min  in  8  BCD preset minutes {tens, units}
- load_sec  in  8  BCD preset seconds {tens, units}
- min  out  8  BCD minutes
- sec  out  8  BCD seconds
- running  out  1  high in RUN
- done  out  1  high in DONE
- tick  out  1  one-cycle pulse on every count update
- load_err  out  1  one-cycle pulse on a rejected load

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset: IDLE, min=8'h00, sec=8'h00, prescaler=0, latched mode=0, all flags 0.
- Command priority when several are high in the same cycle: clear > load > stop > start.
- clear (any state): min=sec=00, prescaler=0, go IDLE.
- load (IDLE, PAUSE, DONE only; ignored in RUN): accept when every nibble ≤9 and sec tens ≤5; then min/sec = preset, prescaler=0, go IDLE. Otherwise count unchanged, state unchanged, load_err pulses.
- IDLE + start: latch mode_sel. Countdown with count 00:00 → stay IDLE. Otherwise go RUN.
- RUN: prescaler counts 0..TICK_DIV-1; on the cycle it equals TICK_DIV-1 it wraps to 0 and the count steps once.
  - Up step: sec units +1; 9→0 carries to sec tens; sec 59→00 carries to min; min units 9→0 carries to min tens.
  - Down step: inverse borrow chain; sec 00→59 borrows from min.
  - Stopwatch: step that yields 99:59 → go DONE holding 99:59.
  - Countdown: step that yields 00:00 → go DONE holding 00:00.
  - stop → PAUSE; prescaler holds its value (partial second preserved).
- PAUSE: count and prescaler hold; start → RUN with the latched mode (mode_sel ignored).
- DONE: count holds; only clear or load leave it; start and stop are ignored.
- mode_sel changes outside IDLE have no effect.

## Timing
- All outputs are registered; no combinational input→output path.
- Command sampled on edge n takes effect on outputs after edge n.
- IDLE → RUN at edge n: first step lands TICK_DIV edges later. After that, one step every TICK_DIV edges.
- tick is high for exactly the one cycle in which the new min/sec value first appears.
- stop asserted in the same cycle as a terminal prescaler value: stop wins; no step, prescaler holds at TICK_DIV-1.
- Resume from PAUSE with prescaler at p: next step after TICK_DIV-p edges.
- Step into the terminal value: count, done and the DONE state all update on the same edge; running falls on that edge.
- rst mid-RUN: everything returns to reset values on the next edge, regardless of other inputs.

## Structure
- Package timer_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - BCD constants: 8'h59 max seconds, 8'h99 max minutes, 8'h00 zero;
  - the BCD nibble-validity check function.
- Sub-module tick_prescaler (clk, rst, en, clr → tick_now, count): parameterised by TICK_DIV, counts only while en, holds otherwise.
- The BCD step chain and the FSM stay in timer_count_ctrl.

## Test plan
All scenarios use TICK_DIV=4.
- Stopwatch basic: reset, mode_sel=0, start pulse → sec 00→01 four edges after RUN entry; after 60 ticks, min=01, sec=00.
- Countdown to done: load 00:02, mode_sel=1, start → 00:01, then 00:00 with done=1 and running=0 on the same edge; a later start is ignored.
- Pause/resume: stop two edges into a second → min/sec and prescaler frozen for 10 cycles; start → step two edges later.
- Bad load: load_sec=8'h6A in IDLE → load_err pulses 1 cycle, count unchanged; load during RUN → ignored, no load_err.
- Priority and wrap: stopwatch preset 99:58 → DONE at 99:59; clear+load+start in the same cycle → 00:00, IDLE.
- Reset mid-RUN at 12:34 → 00:00, IDLE, all flags 0 on the next edge.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the two-mode timer count stage.
//   timer_state_e : count-control FSM states
//   BCD_*         : BCD boundary values of the minutes/seconds display
//   bcd_ok()      : checks that a BCD byte is a legal value with a bounded tens digit
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  localparam logic [7:0] BCD_SEC_MAX = 8'h59;
  localparam logic [7:0] BCD_MIN_MAX = 8'h99;
  localparam logic [7:0] BCD_ZERO    = 8'h00;

  // Units digit must be 0..9, tens digit 0..tens_max.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] tens_max);
    return (v[7:4] <= tens_max) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-second step strobe.
//   clk, rst  : clock, synchronous active-high reset
//   en        : count this cycle (otherwise hold the current phase)
//   clr       : force the phase back to 0 (wins over en)
//   tick_now  : combinational, high when en and the phase is at TICK_DIV-1
//   count     : current phase 0..TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  output logic                        tick_now,
  output logic [$clog2(TICK_DIV)-1:0] count
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick_now = en && (count_q == LAST);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)           count_d = '0;
    else if (tick_now) count_d = '0;
    else if (en)       count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/timer_count_ctrl.sv
// timer_count_ctrl: stopwatch/countdown state machine and BCD step chain.
//   clk, rst            : clock, synchronous active-high reset
//   mode_sel            : 0 count up, 1 count down (latched on leaving IDLE)
//   start/stop/clear/load : level commands, priority clear > load > stop > start
//   load_min/load_sec   : BCD preset
//   min/sec             : BCD count (registered)
//   running/done        : high in RUN / DONE
//   tick                : pulse in the cycle a new count first appears
//   load_err            : pulse after a rejected preset
//   dbg_state_o         : current FSM state
//   dbg_presc_o         : current prescaler phase
// Commands are plain levels with no handshake: whatever is high at a rising
// edge is acted on at that edge, and every output is a register.
module timer_count_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode_sel,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        clear,
  input  logic                        load,
  input  logic [7:0]                  load_min,
  input  logic [7:0]                  load_sec,
  output logic [7:0]                  min,
  output logic [7:0]                  sec,
  output logic                        running,
  output logic                        done,
  output logic                        tick,
  output logic                        load_err,
  output timer_state_e                dbg_state_o,
  output logic [$clog2(TICK_DIV)-1:0] dbg_presc_o
);

  timer_state_e state_q, state_d;
  logic [7:0]   min_q, min_d, sec_q, sec_d;
  logic         mode_q, mode_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;
  logic         pre_en, pre_clr, tick_now;
  logic         load_ok;
  logic [15:0]  stepped;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (pre_en),
    .clr      (pre_clr),
    .tick_now (tick_now),
    .count    (dbg_presc_o)
  );

  // Up step with carry chain; 99:59 wraps to 00:00.
  function automatic logic [15:0] bcd_up(input logic [7:0] m, input logic [7:0] s);
    logic [7:0] mn, sc;
    mn = m;
    sc = s;
    if (sc[3:0] != 4'd9) sc[3:0] = sc[3:0] + 4'd1;
    else begin
      sc[3:0] = 4'd0;
      if (sc[7:4] != 4'd5) sc[7:4] = sc[7:4] + 4'd1;
      else begin
        sc[7:4] = 4'd0;
        if (mn[3:0] != 4'd9) mn[3:0] = mn[3:0] + 4'd1;
        else begin
          mn[3:0] = 4'd0;
          mn[7:4] = (mn[7:4] == 4'd9) ? 4'd0 : mn[7:4] + 4'd1;
        end
      end
    end
    return {mn, sc};
  endfunction

  // Down step with borrow chain; seconds 00 borrow to 59.
  function automatic logic [15:0] bcd_down(input logic [7:0] m, input logic [7:0] s);
    logic [7:0] mn, sc;
    mn = m;
    sc = s;
    if (sc[3:0] != 4'd0) sc[3:0] = sc[3:0] - 4'd1;
    else begin
      sc[3:0] = 4'd9;
      if (sc[7:4] != 4'd0) sc[7:4] = sc[7:4] - 4'd1;
      else begin
        sc[7:4] = 4'd5;
        if (mn[3:0] != 4'd0) mn[3:0] = mn[3:0] - 4'd1;
        else begin
          mn[3:0] = 4'd9;
          mn[7:4] = (mn[7:4] == 4'd0) ? 4'd9 : mn[7:4] - 4'd1;
        end
      end
    end
    return {mn, sc};
  endfunction

  assign load_ok = bcd_ok(load_min, 4'd9) && bcd_ok(load_sec, 4'd5);
  assign stepped = mode_q ? bcd_down(min_q, sec_q) : bcd_up(min_q, sec_q);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    if (clear) begin
      min_d   = BCD_ZERO;
      sec_d   = BCD_ZERO;
      pre_clr = 1'b1;
      state_d = IDLE;
    end else if (load && state_q != RUN) begin
      if (load_ok) begin
        min_d   = load_min;
        sec_d   = load_sec;
        pre_clr = 1'b1;
        state_d = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      // A load seen in RUN falls through here, i.e. it is ignored.
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            mode_d = mode_sel;
            // Countdown from 00:00 has nothing to do.
            if (!(mode_sel && min_q == BCD_ZERO && sec_q == BCD_ZERO)) state_d = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;  // prescaler holds, keeping the partial second
          end else begin
            pre_en = 1'b1;
            if (tick_now) begin
              {min_d, sec_d} = stepped;
              tick_d = 1'b1;
              if (mode_q ? (stepped == {BCD_ZERO, BCD_ZERO})
                         : (stepped == {BCD_MIN_MAX, BCD_SEC_MAX})) state_d = DONE;
            end
          end
        end
        PAUSE: if (start && !stop) state_d = RUN;
        DONE:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= BCD_ZERO;
      sec_q   <= BCD_ZERO;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign min         = min_q;
  assign sec         = sec_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign tick        = tick_q;
  assign load_err    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_count_ctrl.sv
module tb_timer_count_ctrl;
  import timer_pkg::*;

  localparam int TD = 4;
  localparam int EW = 49;  // {cycle[31:0], is_err, min[7:0], sec[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b0, mode_sel = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [7:0] load_min = 8'h00, load_sec = 8'h00;
  logic [7:0] min, sec;
  logic running, done, tick, load_err;
  timer_state_e dbg_state;
  logic [$clog2(TD)-1:0] dbg_presc;

  timer_count_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_min(load_min), .load_sec(load_sec),
    .min(min), .sec(sec), .running(running), .done(done), .tick(tick),
    .load_err(load_err), .dbg_state_o(dbg_state), .dbg_presc_o(dbg_presc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Count kept as total seconds; BCD only produced for comparison.
  int           t = 0;
  int           p = 0;
  logic         m_mode = 1'b0;
  timer_state_e m_state = IDLE;
  bit           armed = 1'b0;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_step();
    if (rst) begin
      t = 0; p = 0; m_mode = 1'b0; m_state = IDLE; armed = 1'b1;
      return;
    end
    if (clear) begin
      t = 0; p = 0; m_state = IDLE;
    end else if (load && m_state != RUN) begin
      if (load_min[7:4] <= 9 && load_min[3:0] <= 9 && load_sec[7:4] <= 5 && load_sec[3:0] <= 9) begin
        t = (load_min[7:4] * 10 + load_min[3:0]) * 60 + load_sec[7:4] * 10 + load_sec[3:0];
        p = 0;
        m_state = IDLE;
      end else begin
        exp_q.push_back({32'(cyc + 1), 1'b1, to_bcd(t)});
      end
    end else begin
      case (m_state)
        IDLE: if (start && !stop) begin
          m_mode = mode_sel;
          if (!(m_mode && t == 0)) m_state = RUN;
        end
        RUN: begin
          if (stop) m_state = PAUSE;
          else if (p == TD - 1) begin
            p = 0;
            t = m_mode ? (t + 5999) % 6000 : (t + 1) % 6000;
            exp_q.push_back({32'(cyc + 1), 1'b0, to_bcd(t)});
            if (m_mode ? (t == 0) : (t == 5999)) m_state = DONE;
          end else p++;
        end
        PAUSE: if (start && !stop) m_state = RUN;
        default: ;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic ms, input logic st, input logic sp,
                       input logic cl, input logic ld, input logic [7:0] lm, input logic [7:0] ls);
    @(negedge clk);
    rst = r; mode_sel = ms; start = st; stop = sp; clear = cl; load = ld;
    load_min = lm; load_sec = ls;
    model_step();
  endtask

  task automatic idle(input int n, input logic ms);
    for (int i = 0; i < n; i++) drive(1'b0, ms, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  always @(posedge clk) begin
    logic [EW-1:0] e;
    logic [15:0]   m_bcd;
    cyc++;
    #1;
    if (armed) begin
      m_bcd = to_bcd(t);
      chk("min", 32'(min), 32'(m_bcd[15:8]));
      chk("sec", 32'(sec), 32'(m_bcd[7:0]));
      chk("running", 32'(running), 32'(m_state == RUN));
      chk("done", 32'(done), 32'(m_state == DONE));
      chk("state", 32'(dbg_state), 32'(m_state));
      chk("presc", 32'(dbg_presc), 32'(p));
      if (tick || load_err) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event at cycle %0d: got tick=%0b load_err=%0b expected none",
                   cyc, tick, load_err);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", 32'(cyc), e[48:17]);
          chk("event_kind", {30'd0, load_err, tick}, e[16] ? 32'd2 : 32'd1);
          chk("event_value", {16'd0, min, sec}, {16'd0, e[15:0]});
        end
      end else if (exp_q.size() != 0 && exp_q[0][48:17] == 32'(cyc)) begin
        e = exp_q.pop_front();
        chk("missing_event", {30'd0, load_err, tick}, e[16] ? 32'd2 : 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] b;
    int r, k;
    drive(1'b1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    drive(1'b1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(2, 0);

    // stopwatch basic: past one full minute
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(250, 0);
    drive(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);

    // countdown 00:02 to done, later start ignored
    drive(0, 1, 0, 0, 0, 1, 8'h00, 8'h02);
    drive(0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(12, 1);
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(6, 0);
    drive(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    // countdown start at 00:00 stays idle
    drive(0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(3, 1);

    // pause / resume with a partial second; stop on the terminal phase
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(6, 0);
    drive(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    idle(10, 1);
    drive(0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(2, 0);
    drive(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    idle(4, 0);
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(9, 0);
    drive(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);

    // bad loads, then load ignored in RUN
    drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h6A);
    drive(0, 0, 0, 0, 0, 1, 8'hA0, 8'h10);
    idle(2, 0);
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(3, 0);
    drive(0, 0, 0, 0, 0, 1, 8'h12, 8'h34);
    drive(0, 0, 0, 0, 0, 1, 8'h12, 8'h7F);
    idle(6, 0);

    // stopwatch 99:58 -> done at 99:59; then clear+load+start together
    drive(0, 0, 0, 0, 0, 1, 8'h99, 8'h58);
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(8, 0);
    drive(0, 0, 1, 1, 0, 0, 8'h00, 8'h00);
    drive(0, 0, 1, 0, 1, 1, 8'h45, 8'h12);
    idle(2, 0);

    // reset in the middle of a run from 12:34
    drive(0, 1, 0, 0, 0, 1, 8'h12, 8'h34);
    drive(0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
    idle(9, 1);
    drive(1, 1, 1, 0, 0, 1, 8'h11, 8'h11);
    idle(3, 0);

    // randomized commands
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      k = (r < 3) ? $urandom_range(0, 6) : (r < 6) ? $urandom_range(5990, 5999) : $urandom_range(0, 5999);
      b = to_bcd(k);
      if ($urandom_range(0, 9) == 0) b = 16'($urandom);
      drive(($urandom_range(0, 499) == 0), 1'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 29) == 0), b[15:8], b[7:0]);
    end
    idle(4, 0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
